// File: rtl/tlc_txn_tracker.sv
// Protocol monitor for a cached-link transaction flow: tracks Acquire/Grant/GrantAck and Release/ReleaseAck.
// Errors are reported one cycle after the offending fire. Passive: it observes handshakes and never stalls them.
module tlc_txn_tracker #(
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        a_valid,
   input  logic        a_ready,
   input  logic [2:0]  a_opcode,
   input  logic [5:0]  a_source,
   input  logic        c_valid,
   input  logic        c_ready,
   input  logic [2:0]  c_opcode,
   input  logic [2:0]  c_size,
   input  logic [5:0]  c_source,
   input  logic        d_valid,
   input  logic        d_ready,
   input  logic [2:0]  d_opcode,
   input  logic [2:0]  d_size,
   input  logic [5:0]  d_source,
   input  logic [5:0]  d_sink,
   input  logic        e_valid,
   input  logic        e_ready,
   input  logic [5:0]  e_sink,
   output logic        err_valid,
   output logic [3:0]  err_code,
   output logic [5:0]  err_id,
   output logic [15:0] err_cnt,
   output logic [6:0]  acq_outstanding,
   output logic        timeout
);

   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [63:0] acq_pend, rel_pend, sink_busy;
   logic [63:0] acq_set, acq_clr, rel_set, rel_clr, busy_set, busy_clr;
   logic [63:0] acq_nxt;
   logic        d_beat, c_beat;
   logic [15:0] wd_cnt;
   logic        a_fire, c_fire, d_fire, e_fire;
   logic        d_multi, c_multi, d_last, c_last;
   logic        pend_any, wd_hit;
   logic [7:0]  err_hit;
   logic [3:0]  err_num;
   logic [3:0]  code_nxt;
   logic [5:0]  id_nxt;
   logic [6:0]  pop_nxt;
   logic [16:0] err_sum;

   assign a_fire  = a_valid && a_ready;
   assign c_fire  = c_valid && c_ready;
   assign d_fire  = d_valid && d_ready;
   assign e_fire  = e_valid && e_ready;
   assign d_multi = (d_opcode == 3'd5) && (d_size == 3'd6);
   assign c_multi = (c_opcode == 3'd7) && (c_size == 3'd6);
   assign d_last  = !d_multi || d_beat;
   assign c_last  = !c_multi || c_beat;

   assign pend_any = (|acq_pend) || (|rel_pend);
   assign wd_hit   = pend_any && !d_fire && (wd_cnt == WD_LAST);

   // err_hit[n] flags error code n+1; every check reads start-of-cycle state
   always_comb begin
      acq_set  = '0;
      acq_clr  = '0;
      rel_set  = '0;
      rel_clr  = '0;
      busy_set = '0;
      busy_clr = '0;
      err_hit  = '0;
      if (a_fire) begin
         if (a_opcode == 3'd6 || a_opcode == 3'd7) begin
            if (acq_pend[a_source]) err_hit[0] = 1'b1;
            else                    acq_set[a_source] = 1'b1;
         end else begin
            err_hit[7] = 1'b1;
         end
      end
      if (c_fire && c_last && (c_opcode == 3'd6 || c_opcode == 3'd7)) begin
         if (rel_pend[c_source]) err_hit[4] = 1'b1;
         else                    rel_set[c_source] = 1'b1;
      end
      if (d_fire && d_last && (d_opcode == 3'd4 || d_opcode == 3'd5)) begin
         if (!acq_pend[d_source]) err_hit[1] = 1'b1;
         else                     acq_clr[d_source] = 1'b1;
         if (sink_busy[d_sink])   err_hit[2] = 1'b1;
         else                     busy_set[d_sink] = 1'b1;
      end
      if (d_fire && d_opcode == 3'd6) begin
         if (!rel_pend[d_source]) err_hit[5] = 1'b1;
         else                     rel_clr[d_source] = 1'b1;
      end
      if (e_fire) begin
         if (!sink_busy[e_sink]) err_hit[3] = 1'b1;
         else                    busy_clr[e_sink] = 1'b1;
      end
      err_hit[6] = wd_hit;
   end

   assign acq_nxt = (acq_pend & ~acq_clr) | acq_set;

   // descending scan so the lowest code present wins
   always_comb begin
      err_num  = '0;
      code_nxt = '0;
      for (int i = 7; i >= 0; i--) begin
         err_num = err_num + 4'(err_hit[i]);
         if (err_hit[i]) code_nxt = 4'(i + 1);
      end
   end

   always_comb begin
      id_nxt = '0;
      case (code_nxt)
         4'd1, 4'd8: id_nxt = a_source;
         4'd2, 4'd6: id_nxt = d_source;
         4'd3:       id_nxt = d_sink;
         4'd4:       id_nxt = e_sink;
         4'd5:       id_nxt = c_source;
         default:    id_nxt = '0;
      endcase
   end

   always_comb begin
      pop_nxt = '0;
      for (int i = 0; i < 64; i++) pop_nxt = pop_nxt + 7'(acq_nxt[i]);
   end

   assign err_sum = {1'b0, err_cnt} + 17'(err_num);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acq_pend        <= '0;
         rel_pend        <= '0;
         sink_busy       <= '0;
         d_beat          <= 1'b0;
         c_beat          <= 1'b0;
         wd_cnt          <= '0;
         timeout         <= 1'b0;
         err_valid       <= 1'b0;
         err_code        <= '0;
         err_id          <= '0;
         err_cnt         <= '0;
         acq_outstanding <= '0;
      end else begin
         acq_pend        <= acq_nxt;
         rel_pend        <= (rel_pend & ~rel_clr) | rel_set;
         sink_busy       <= (sink_busy & ~busy_clr) | busy_set;
         acq_outstanding <= pop_nxt;
         if (d_fire && d_multi) d_beat <= !d_beat;
         if (c_fire && c_multi) c_beat <= !c_beat;
         if (d_fire || !pend_any || wd_hit) wd_cnt <= '0;
         else                               wd_cnt <= wd_cnt + 16'd1;
         if (wd_hit) timeout <= 1'b1;
         err_valid <= (err_num != 4'd0);
         if (err_num != 4'd0) begin
            err_code <= code_nxt;
            err_id   <= id_nxt;
            err_cnt  <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
         end
      end
   end

endmodule

// File: tb/tb_tlc_txn_tracker.sv
// Directed bench for tlc_txn_tracker with a 16-cycle watchdog.
module tb_tlc_txn_tracker;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        a_valid, a_ready;
   logic [2:0]  a_opcode;
   logic [5:0]  a_source;
   logic        c_valid, c_ready;
   logic [2:0]  c_opcode, c_size;
   logic [5:0]  c_source;
   logic        d_valid, d_ready;
   logic [2:0]  d_opcode, d_size;
   logic [5:0]  d_source, d_sink;
   logic        e_valid, e_ready;
   logic [5:0]  e_sink;
   logic        err_valid;
   logic [3:0]  err_code;
   logic [5:0]  err_id;
   logic [15:0] err_cnt;
   logic [6:0]  acq_outstanding;
   logic        timeout;

   int total = 0;
   int bad   = 0;

   tlc_txn_tracker #(.TIMEOUT_CYCLES(16)) dut (
      .clock(clock), .reset_n(reset_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_source(a_source),
      .c_valid(c_valid), .c_ready(c_ready), .c_opcode(c_opcode), .c_size(c_size), .c_source(c_source),
      .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
      .d_source(d_source), .d_sink(d_sink),
      .e_valid(e_valid), .e_ready(e_ready), .e_sink(e_sink),
      .err_valid(err_valid), .err_code(err_code), .err_id(err_id), .err_cnt(err_cnt),
      .acq_outstanding(acq_outstanding), .timeout(timeout)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      a_valid = 1'b0;
      c_valid = 1'b0;
      d_valid = 1'b0;
      e_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
   endtask

   task automatic drv_a(input logic [2:0] op, input logic [5:0] src);
      a_valid = 1'b1; a_opcode = op; a_source = src;
   endtask

   task automatic drv_c(input logic [2:0] op, input logic [2:0] sz, input logic [5:0] src);
      c_valid = 1'b1; c_opcode = op; c_size = sz; c_source = src;
   endtask

   task automatic drv_d(input logic [2:0] op, input logic [2:0] sz, input logic [5:0] src,
                        input logic [5:0] snk);
      d_valid = 1'b1; d_opcode = op; d_size = sz; d_source = src; d_sink = snk;
   endtask

   task automatic drv_e(input logic [5:0] snk);
      e_valid = 1'b1; e_sink = snk;
   endtask

   initial begin
      reset_n = 1'b1;
      a_valid = 1'b0; a_ready = 1'b1; a_opcode = '0; a_source = '0;
      c_valid = 1'b0; c_ready = 1'b1; c_opcode = '0; c_size = '0; c_source = '0;
      d_valid = 1'b0; d_ready = 1'b1; d_opcode = '0; d_size = '0; d_source = '0; d_sink = '0;
      e_valid = 1'b0; e_ready = 1'b1; e_sink = '0;
      #2 reset_n = 1'b0;
      #2;
      chk("rst_err_valid", 16'(err_valid), 16'd0);
      chk("rst_err_cnt", err_cnt, 16'd0);
      chk("rst_acq", 16'(acq_outstanding), 16'd0);
      chk("rst_timeout", 16'(timeout), 16'd0);
      chk("rst_err_code", 16'(err_code), 16'd0);
      @(posedge clock);
      #1 reset_n = 1'b1;

      // legal Acquire / 2-beat GrantData / GrantAck
      drv_a(3'd6, 6'd5); tick();
      chk("legal_acq1", 16'(acq_outstanding), 16'd1);
      drv_d(3'd5, 3'd6, 6'd5, 6'd9); tick();
      chk("legal_beat1_noerr", 16'(err_valid), 16'd0);
      tick();
      chk("legal_acq_after_beat1", 16'(acq_outstanding), 16'd1);
      drv_d(3'd5, 3'd6, 6'd5, 6'd9); tick();
      chk("legal_acq_after_beat2", 16'(acq_outstanding), 16'd0);
      chk("legal_beat2_noerr", 16'(err_valid), 16'd0);
      drv_e(6'd9); tick();
      chk("legal_ack_noerr", 16'(err_valid), 16'd0);
      chk("legal_cnt", err_cnt, 16'd0);

      // duplicate Acquire
      do_reset();
      drv_a(3'd6, 6'd3); tick();
      drv_a(3'd7, 6'd3); tick();
      chk("dup_valid", 16'(err_valid), 16'd1);
      chk("dup_code", 16'(err_code), 16'd1);
      chk("dup_id", 16'(err_id), 16'd3);
      chk("dup_cnt", err_cnt, 16'd1);
      tick();
      chk("dup_pulse_end", 16'(err_valid), 16'd0);
      chk("dup_code_hold", 16'(err_code), 16'd1);

      // unsolicited GrantAck, then Grant+GrantAck collision on sink 7
      do_reset();
      drv_e(6'd12); tick();
      chk("ack12_code", 16'(err_code), 16'd4);
      chk("ack12_id", 16'(err_id), 16'd12);
      drv_a(3'd6, 6'd0); tick();
      drv_d(3'd4, 3'd0, 6'd0, 6'd7); drv_e(6'd7); tick();
      chk("coll_valid", 16'(err_valid), 16'd1);
      chk("coll_code", 16'(err_code), 16'd4);
      chk("coll_id", 16'(err_id), 16'd7);
      chk("coll_cnt", err_cnt, 16'd2);
      drv_e(6'd7); tick();
      chk("coll_sink_busy", 16'(err_valid), 16'd0);
      chk("coll_cnt_hold", err_cnt, 16'd2);

      // three errors in one cycle: codes 8, 4, 6
      do_reset();
      drv_a(3'd0, 6'd10); drv_e(6'd20); drv_d(3'd6, 3'd0, 6'd11, 6'd0); tick();
      chk("multi_cnt", err_cnt, 16'd3);
      chk("multi_code", 16'(err_code), 16'd4);
      chk("multi_id", 16'(err_id), 16'd20);
      chk("multi_acq", 16'(acq_outstanding), 16'd0);

      // A and Grant to the same source in one cycle
      do_reset();
      drv_a(3'd6, 6'd8); drv_d(3'd4, 3'd0, 6'd8, 6'd1); tick();
      chk("ad_code", 16'(err_code), 16'd2);
      chk("ad_id", 16'(err_id), 16'd8);
      chk("ad_acq_set", 16'(acq_outstanding), 16'd1);
      drv_d(3'd4, 3'd0, 6'd8, 6'd2); tick();
      chk("ad_grant_ok", 16'(err_valid), 16'd0);
      chk("ad_acq_clr", 16'(acq_outstanding), 16'd0);

      // Release tracking and 2-beat ReleaseData
      do_reset();
      drv_c(3'd6, 3'd0, 6'd2); tick();
      chk("rel_first_ok", 16'(err_valid), 16'd0);
      drv_c(3'd6, 3'd0, 6'd2); tick();
      chk("rel_dup_code", 16'(err_code), 16'd5);
      chk("rel_dup_id", 16'(err_id), 16'd2);
      drv_d(3'd6, 3'd0, 6'd2, 6'd0); tick();
      chk("relack_ok", 16'(err_valid), 16'd0);
      drv_c(3'd7, 3'd6, 6'd4); tick();
      drv_d(3'd6, 3'd0, 6'd4, 6'd0); tick();
      chk("reldata_beat1_code", 16'(err_code), 16'd6);
      chk("reldata_beat1_id", 16'(err_id), 16'd4);
      chk("reldata_beat1_cnt", err_cnt, 16'd2);
      drv_c(3'd7, 3'd6, 6'd4); tick();
      drv_d(3'd6, 3'd0, 6'd4, 6'd0); tick();
      chk("reldata_beat2_ok", 16'(err_valid), 16'd0);
      chk("reldata_cnt_hold", err_cnt, 16'd2);

      // watchdog
      do_reset();
      drv_a(3'd6, 6'd1); tick();
      for (int i = 1; i <= 15; i++) begin
         tick();
         chk($sformatf("wd_early_%0d", i), 16'(timeout), 16'd0);
      end
      tick();
      chk("wd_timeout", 16'(timeout), 16'd1);
      chk("wd_valid", 16'(err_valid), 16'd1);
      chk("wd_code", 16'(err_code), 16'd7);
      chk("wd_id", 16'(err_id), 16'd0);
      chk("wd_cnt", err_cnt, 16'd1);
      tick();
      chk("wd_pulse_end", 16'(err_valid), 16'd0);
      chk("wd_sticky", 16'(timeout), 16'd1);

      // reset in the middle of a GrantData
      do_reset();
      drv_e(6'd30); tick();
      drv_a(3'd6, 6'd5); tick();
      drv_d(3'd5, 3'd6, 6'd5, 6'd9); tick();
      chk("mid_pre_acq", 16'(acq_outstanding), 16'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_acq", 16'(acq_outstanding), 16'd0);
      chk("mid_rst_cnt", err_cnt, 16'd0);
      chk("mid_rst_code", 16'(err_code), 16'd0);
      chk("mid_rst_id", 16'(err_id), 16'd0);
      reset_n = 1'b1;
      drv_d(3'd5, 3'd6, 6'd5, 6'd9); tick();
      chk("post_beat1_noerr", 16'(err_valid), 16'd0);
      drv_d(3'd5, 3'd6, 6'd5, 6'd9); tick();
      chk("post_grant_code", 16'(err_code), 16'd2);
      chk("post_grant_id", 16'(err_id), 16'd5);
      drv_d(3'd6, 3'd0, 6'd2, 6'd0); tick();
      chk("post_relack_code", 16'(err_code), 16'd6);
      chk("post_relack_id", 16'(err_id), 16'd2);
      chk("post_cnt", err_cnt, 16'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tlc_txn_tracker.md
TLC_TXN_TRACKER -- requirements
Module: tlc_txn_tracker

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 4096, meaning watchdog limit in cycles (range 2..65535).
REQ-002 clock  in  1  sole clock; all state updates on posedge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 a_valid, a_ready  in  1 each  Channel A handshake; a_opcode  in  3; a_source  in  6.
REQ-005 c_valid, c_ready  in  1 each  Channel C handshake; c_opcode  in  3; c_size  in  3; c_source  in  6.
REQ-006 d_valid, d_ready  in  1 each  Channel D handshake; d_opcode  in  3; d_size  in  3; d_source  in  6; d_sink  in  6.
REQ-007 e_valid, e_ready  in  1 each  Channel E handshake; e_sink  in  6.
REQ-008 err_valid  out  1  one-cycle error pulse.
REQ-009 err_code  out  4  code of the reported error; err_id  out  6  offending source or sink.
REQ-010 err_cnt  out  16  total errors detected, saturating at 16'hFFFF.
REQ-011 acq_outstanding  out  7  count of sources with an Acquire pending.
REQ-012 timeout  out  1  sticky watchdog flag.

Function
REQ-013 Fire on a channel SHALL mean valid && ready in the same cycle; no other condition updates state.
REQ-014 State: acq_pend[64] and rel_pend[64] indexed by source; sink_busy[64] indexed by sink; D and C beat flags.
REQ-015 A fire, opcode 6 or 7: if acq_pend[src] is set -> error 1, otherwise set acq_pend[src]. Any other opcode -> error 8, no state change.
REQ-016 C fire, opcode 6 (Release) or 7 (ReleaseData), on the last beat: if rel_pend[src] is set -> error 5, otherwise set it. Opcode 4/5 (ProbeAck/ProbeAckData) is not tracked.
REQ-017 D fire, opcode 4 (Grant) or 5 (GrantData), on the last beat:
  - if !acq_pend[src] -> error 2;
  - else clear acq_pend[src];
  - if sink_busy[sink] -> error 3;
  - else set sink_busy[sink].
REQ-018 D fire, opcode 6 (ReleaseAck): if !rel_pend[src] -> error 6, otherwise clear it.
REQ-019 E fire: if !sink_busy[sink] -> error 4, otherwise clear sink_busy[sink].
REQ-020 Beat rule: opcodes 5 (D) and 7 (C) with size 6 span 2 beats (256-bit data). A per-channel first-beat flag marks the first beat; that beat only toggles the flag. All other messages are single-beat.
REQ-021 Simultaneous events: every check uses state from the start of the cycle; all updates apply at the cycle end.
  - An A and a D to the same source in one cycle -> error 2; acq_pend ends set.
  - A D Grant and an E to the same sink in one cycle -> error 4; sink_busy ends set.
REQ-022 Multiple errors in one cycle: err_cnt increments by the number of errors; err_code/err_id report the lowest code only.
REQ-023 err_valid, err_code and err_id SHALL be registered, appearing one cycle after the offending fire; err_code/err_id hold between pulses.
REQ-024 Watchdog: a 16-bit counter increments each cycle while any acq_pend or rel_pend bit is set. It clears on any D fire or when nothing is pending. On reaching TIMEOUT_CYCLES: set timeout, pulse error 7 (err_id 0), then restart the count from 0.
REQ-025 acq_outstanding SHALL equal the popcount of acq_pend, registered, and update the cycle after the change.

Reset
REQ-026 On reset_n low, without waiting for a clock edge: clear all pend/busy bits, beat flags, watchdog, timeout, err_valid and err_cnt; drive err_code and err_id to 0 and acq_outstanding to 0.
REQ-027 Reset mid-transaction SHALL discard all pending state; the first post-reset D Grant for any source is therefore error 2.

Verification
REQ-028 Legal flow:
  - AcquireBlock source 5 -> acq_outstanding 1;
  - 2-beat GrantData size 6, source 5, sink 9 -> acq_outstanding 0 after beat 2 only;
  - GrantAck sink 9 -> no error, err_cnt 0.
REQ-029 Duplicate Acquire on source 3 without an intervening Grant -> err_valid pulse, err_code 1, err_id 3, err_cnt 1.
REQ-030 GrantAck sink 12 with no Grant outstanding -> err_code 4, err_id 12. Grant and GrantAck on sink 7 in the same cycle -> err_code 4, sink 7 left busy.
REQ-031 TIMEOUT_CYCLES=16, Acquire source 1, no D traffic -> timeout set and err_code 7 exactly 16 cycles after the first pending cycle; timeout stays 1.
REQ-032 Assert reset_n low mid-GrantData (after beat 1) -> outputs zero immediately. After release, ReleaseAck source 2 -> err_code 6.
